apb_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one APB completer (the 4-register APB slave) between `NREQ` independent requesters. Each requester issues single read/write transactions over a simple valid/ready request channel plus a response pulse. The arbiter runs the APB SETUP/ACCESS protocol and steers the result back to the granted requester. A bounded PREADY timeout guarantees forward progress when the completer hangs.

---
 rtl/apb_rr_arbiter_if.sv | 34 +++
 rtl/apb_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_arbiter_if.sv
// Requester channels and APB completer bus shared by the round-robin arbiter.
// "master" is the arbiter's view; "slave" is the requesters' and completer's view.
interface apb_rr_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W-1:0]      prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB completer between NREQ requesters,
// with a bounded PREADY timeout that forces an error response.
module apb_rr_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  apb_rr_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  // Flat request buses viewed as per-requester lanes (identical bit layout).
  logic [NREQ-1:0][ADDR_W-1:0] addr_a;
  logic [NREQ-1:0][DATA_W-1:0] wdata_a;
  assign addr_a  = bus.req_addr;
  assign wdata_a = bus.req_wdata;

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [CW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NREQ-1:0]   rdy_q, rdy_d;
  logic [NREQ-1:0]   rspv_q, rspv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              gnt_vld;
  logic [GW-1:0]     gnt_idx;

  // Scan from farthest to nearest after last_q so the nearest pending requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[GW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

  assign tmo_inc = tmo_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdy_d     = '0;
    rspv_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d        = S_SETUP;
          last_d         = gnt_idx;
          paddr_d        = addr_a[gnt_idx];
          pwdata_d       = wdata_a[gnt_idx];
          pwrite_d       = bus.req_write[gnt_idx];
          psel_d         = 1'b1;
          rdy_d[gnt_idx] = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        tmo_d     = '0;
      end
      S_ACCESS: begin
        if (!bus.pready) tmo_d = tmo_inc;
        // A late PREADY on the last allowed cycle still completes normally.
        if (bus.pready || tmo_inc == CW'(TIMEOUT)) begin
          state_d        = S_IDLE;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          rspv_d[last_q] = 1'b1;
          rdata_d        = (bus.pready && !pwrite_q) ? bus.prdata : '0;
          err_d          = bus.pready ? bus.pslverr : 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= GW'(NREQ - 1);
      tmo_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdy_q     <= '0;
      rspv_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdy_q     <= rdy_d;
      rspv_q    <= rspv_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rspv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: 4-register APB completer with programmable waits/errors,
// transaction-level round-robin reference model, directed vectors and random traffic.
module tb_apb_rr_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  typedef struct {int r; bit wr; logic [31:0] addr; logic [31:0] wdata; int w; bit e;} txn_t;
  typedef struct {int idx; logic [31:0] rdata; bit err; int lat; int pen;} rsp_t;
  typedef struct {txn_t t; logic [31:0] x_rdata; bit x_err; int x_lat; int x_pen;} vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
  apb_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Completer: PREADY after wait_n ACCESS cycles, PSLVERR when err_force.
  logic [31:0] cmem [4] = '{default: '0};
  int wait_n = 0;
  bit err_force = 1'b0;
  int acc_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.psel && bus.penable) begin
      acc_cnt <= acc_cnt + 1;
      if (bus.pready && bus.pwrite && !err_force) cmem[bus.paddr[3:2]] <= bus.pwdata;
    end else acc_cnt <= 0;
  end
  assign bus.pready  = bus.psel && bus.penable && (acc_cnt >= wait_n);
  assign bus.pslverr = bus.psel && bus.penable && err_force;
  assign bus.prdata  = cmem[bus.paddr[3:2]];

  int n_cmp = 0, n_bad = 0;
  txn_t pool[$];
  rsp_t log_q[$];
  logic [31:0] ref_mem [4];
  int inflight = -1, cur_h = 0, t_ready = 0, pen_cnt = 0, m_last = NREQ - 1;
  txn_t cur;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int find_head(input int r);
    foreach (pool[j]) if (pool[j].r == r) return j;
    return -1;
  endfunction

  task automatic drive_reqs();
    logic [NREQ-1:0] v, w;
    logic [NREQ-1:0][AW-1:0] a;
    logic [NREQ-1:0][DW-1:0] d;
    int h;
    v = '0; w = bus.req_write; a = bus.req_addr; d = bus.req_wdata;
    for (int i = 0; i < NREQ; i++) begin
      h = find_head(i);
      if (h >= 0 && inflight != i) begin
        v[i] = 1'b1; w[i] = pool[h].wr; a[i] = pool[h].addr; d[i] = pool[h].wdata;
      end
    end
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
  endtask

  task automatic monitor_step();
    logic [NREQ-1:0] rdy, rv, oh;
    int g, xl, xp;
    bit tmo, xe;
    logic [31:0] xr;
    rdy = bus.req_ready; rv = bus.rsp_valid;
    if (inflight >= 0 && bus.penable) pen_cnt++;
    if (rv != '0) begin
      if (inflight < 0) chk("spurious_rsp", 64'(rv), 64'd0);
      else begin
        tmo = (cur.w >= TMO);
        xl  = tmo ? TMO + 1 : 2 + cur.w;
        xp  = tmo ? TMO : cur.w + 1;
        xe  = tmo ? 1'b1 : cur.e;
        xr  = (tmo || cur.wr) ? 32'd0 : ref_mem[cur.addr[3:2]];
        oh = '0; oh[inflight] = 1'b1;
        chk("rsp_onehot", 64'(rv), 64'(oh));
        chk("rsp_latency", 64'(cyc - t_ready), 64'(xl));
        chk("penable_cycles", 64'(pen_cnt), 64'(xp));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(xr));
        chk("rsp_err", 64'(bus.rsp_err), 64'(xe));
        chk("paddr_hold", 64'(bus.paddr), 64'(cur.addr));
        if (cur.wr && !tmo && !cur.e) ref_mem[cur.addr[3:2]] = cur.wdata;
        log_q.push_back('{inflight, bus.rsp_rdata, bus.rsp_err, cyc - t_ready, pen_cnt});
        pool.delete(cur_h);
        inflight = -1;
      end
    end
    if (rdy != '0) begin
      if (inflight >= 0) chk("spurious_ready", 64'(rdy), 64'd0);
      else begin
        g = -1;
        for (int k = NREQ; k >= 1; k--) if (find_head((m_last + k) % NREQ) >= 0) g = (m_last + k) % NREQ;
        if (g < 0) chk("ready_without_req", 64'(rdy), 64'd0);
        else begin
          oh = '0; oh[g] = 1'b1;
          chk("grant", 64'(rdy), 64'(oh));
          chk("setup_phase", 64'({bus.psel, bus.penable}), 64'(2'b10));
          cur_h = find_head(g); cur = pool[cur_h];
          chk("paddr", 64'(bus.paddr), 64'(cur.addr));
          chk("pwrite", 64'(bus.pwrite), 64'(cur.wr));
          if (cur.wr) chk("pwdata", 64'(bus.pwdata), 64'(cur.wdata));
          wait_n = cur.w; err_force = cur.e;
          inflight = g; m_last = g; t_ready = cyc; pen_cnt = 0;
        end
      end
    end
  endtask

  task automatic serve_all(input int budget);
    int n;
    n = 0;
    drive_reqs();
    while ((pool.size() > 0 || inflight >= 0) && n < budget) begin
      @(negedge clk);
      n++;
      monitor_step();
      drive_reqs();
    end
    if (pool.size() > 0 || inflight >= 0) begin
      n_cmp++; n_bad++;
      $display("FAIL serve_budget: %0d txns outstanding after %0d cycles, required 0", pool.size(), budget);
      pool.delete(); inflight = -1; drive_reqs();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    rsp_t r;
    int base;
    bit seen;
    txn_t t;

    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;

    // {r, wr, addr, wdata, waits, err}, exp rdata, exp err, exp latency (ready->rsp), exp ACCESS cycles
    tbl[0] = '{'{0, 1'b1, 32'h0, 32'd17,       0,    1'b0}, 32'd0,        1'b0, 2,       1};
    tbl[1] = '{'{0, 1'b1, 32'h4, 32'd19102025, 0,    1'b0}, 32'd0,        1'b0, 2,       1};
    tbl[2] = '{'{1, 1'b0, 32'h4, 32'd0,        0,    1'b0}, 32'd19102025, 1'b0, 2,       1};
    tbl[3] = '{'{0, 1'b0, 32'h0, 32'd0,        3,    1'b0}, 32'd17,       1'b0, 5,       4};
    tbl[4] = '{'{1, 1'b1, 32'h8, 32'hCAFEF00D, 1,    1'b1}, 32'd0,        1'b1, 3,       2};
    tbl[5] = '{'{0, 1'b0, 32'h8, 32'd0,        0,    1'b0}, 32'h54737962, 1'b0, 2,       1};
    tbl[6] = '{'{1, 1'b0, 32'hC, 32'd0,        1000, 1'b0}, 32'd0,        1'b1, TMO + 1, TMO};
    tbl[7] = '{'{0, 1'b0, 32'hC, 32'd0,        0,    1'b0}, 32'h416E6173, 1'b0, 2,       1};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);

    // Both requesters pending at reset release, each re-requesting after completion.
    pool.push_back('{0, 1'b1, 32'h8, 32'h54737962, 0, 1'b0});
    pool.push_back('{1, 1'b1, 32'hC, 32'h416E6173, 0, 1'b0});
    pool.push_back('{0, 1'b0, 32'h8, 32'h0, 0, 1'b0});
    pool.push_back('{1, 1'b0, 32'hC, 32'h0, 0, 1'b0});
    drive_reqs();
    reset = 1'b0;
    serve_all(100);
    if (log_q.size() == 4) begin
      chk("alt_grant0", 64'(log_q[0].idx), 64'd0);
      chk("alt_grant1", 64'(log_q[1].idx), 64'd1);
      chk("alt_grant2", 64'(log_q[2].idx), 64'd0);
      chk("alt_grant3", 64'(log_q[3].idx), 64'd1);
      chk("alt_read_tsyb", 64'(log_q[2].rdata), 64'h54737962);
      chk("alt_read_anas", 64'(log_q[3].rdata), 64'h416E6173);
    end else chk("alt_rsp_count", 64'(log_q.size()), 64'd4);
    repeat (2) @(negedge clk);
    chk("rsp_pulse_single", 64'(bus.rsp_valid), 64'd0);
    chk("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'h416E6173);

    foreach (tbl[j]) begin
      base = log_q.size();
      pool.push_back(tbl[j].t);
      serve_all(60);
      if (log_q.size() == base + 1) begin
        r = log_q[base];
        chk($sformatf("vec%0d_idx", j), 64'(r.idx), 64'(tbl[j].t.r));
        chk($sformatf("vec%0d_rdata", j), 64'(r.rdata), 64'(tbl[j].x_rdata));
        chk($sformatf("vec%0d_err", j), 64'(r.err), 64'(tbl[j].x_err));
        chk($sformatf("vec%0d_lat", j), 64'(r.lat), 64'(tbl[j].x_lat));
        chk($sformatf("vec%0d_pen", j), 64'(r.pen), 64'(tbl[j].x_pen));
      end else chk($sformatf("vec%0d_rsp_count", j), 64'(log_q.size()), 64'(base + 1));
    end

    // Reset during ACCESS with a hung completer.
    wait_n = 1000; err_force = 1'b0;
    @(negedge clk);
    bus.req_write = '0; bus.req_addr[AW +: AW] = 32'hC; bus.req_valid = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) seen = 1'b1;
    end
    chk("abort_ready_seen", 64'(seen), 64'd1);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    chk("abort_in_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
    #2 reset = 1'b1;
    #1;
    chk("abort_psel", 64'(bus.psel), 64'd0);
    chk("abort_penable", 64'(bus.penable), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    reset = 1'b0;
    m_last = NREQ - 1; inflight = -1;
    base = log_q.size();
    pool.push_back('{1, 1'b0, 32'h4, 32'h0, 0, 1'b0});
    pool.push_back('{0, 1'b0, 32'h0, 32'h0, 0, 1'b0});
    serve_all(60);
    if (log_q.size() == base + 2) begin
      chk("post_reset_first_grant", 64'(log_q[base].idx), 64'd0);
      chk("post_reset_second_grant", 64'(log_q[base + 1].idx), 64'd1);
    end else chk("post_reset_rsp_count", 64'(log_q.size()), 64'(base + 2));

    // Random traffic against the transaction-level model.
    for (int b = 0; b < 30; b++) begin
      for (int k = 0, n = int'($urandom_range(1, 5)); k < n; k++) begin
        t.r     = int'($urandom_range(0, NREQ - 1));
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
        t.wdata = $urandom;
        t.w     = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
        t.e     = ($urandom_range(0, 7) == 0);
        pool.push_back(t);
      end
      serve_all(400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
